// File: rtl/dds_sweep_ctrl.sv
`timescale 1ns/1ps
// DDS sweep sequencer: steps TuningWord StartTW->StopTW by StepTW, each word held DwellCnt DDSEnable ticks; outputs registered,
// TwValid one cycle after LOAD/STEP, no backpressure (DDSEnable paces). Define SWEEP_PINGPONG_EN to sweep back down to StartTW.
module dds_sweep_ctrl #(
    parameter int TW_W    = 32,
    parameter int DWELL_W = 16
) (
    input  logic               Fg_CLK,
    input  logic               Fg_RESETn,
    input  logic               DDSEnable,
    input  logic               Start,
    input  logic               Abort,
    input  logic [TW_W-1:0]    StartTW,
    input  logic [TW_W-1:0]    StopTW,
    input  logic [TW_W-1:0]    StepTW,
    input  logic [DWELL_W-1:0] DwellCnt,
    output logic [TW_W-1:0]    TuningWord,
    output logic               TwValid,
    output logic               Busy,
    output logic               Done
);
    typedef enum logic [2:0] {IDLE, LOAD, DWELL, STEP, FINISH} state_t;

    state_t             state, state_nxt;
    logic [TW_W-1:0]    start_q, stop_q, step_q;
    logic [TW_W-1:0]    start_nxt, stop_nxt, step_nxt, tw_nxt, up_tw;
    logic [DWELL_W-1:0] dwell_q, dwell_nxt, cnt, cnt_nxt, cnt_inc, dwell_max;
    logic               vld_nxt, busy_nxt, done_nxt, no_sweep;
    logic [TW_W:0]      sum;
`ifdef SWEEP_PINGPONG_EN
    logic               dir, dir_nxt;
    logic [TW_W:0]      diff;
    logic [TW_W-1:0]    dn_tw;
`endif

    assign cnt_inc   = cnt + DWELL_W'(1);
    assign dwell_max = (dwell_q == '0) ? DWELL_W'(1) : dwell_q;
    assign no_sweep  = (step_q == '0) || (start_q >= stop_q);
    // Extra carry bit makes the overflow case fall into the saturate branch
    assign sum       = {1'b0, TuningWord} + {1'b0, step_q};
    assign up_tw     = (sum >= {1'b0, stop_q}) ? stop_q : sum[TW_W-1:0];
`ifdef SWEEP_PINGPONG_EN
    assign diff      = {1'b0, TuningWord} - {1'b0, step_q};
    assign dn_tw     = (diff[TW_W] || (diff[TW_W-1:0] <= start_q)) ? start_q : diff[TW_W-1:0];
`endif

    always_ff @(posedge Fg_CLK) begin
        if (!Fg_RESETn) state <= IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start_nxt = start_q;
        stop_nxt  = stop_q;
        step_nxt  = step_q;
        dwell_nxt = dwell_q;
        tw_nxt    = TuningWord;
        cnt_nxt   = cnt;
        vld_nxt   = 1'b0;
        done_nxt  = 1'b0;
        busy_nxt  = Busy;
`ifdef SWEEP_PINGPONG_EN
        dir_nxt   = dir;
`endif
        case (state)
            IDLE: begin
                if (Start && !Abort) begin
                    start_nxt = StartTW;
                    stop_nxt  = StopTW;
                    step_nxt  = StepTW;
                    dwell_nxt = DwellCnt;
                    busy_nxt  = 1'b1;
                    state_nxt = LOAD;
`ifdef SWEEP_PINGPONG_EN
                    dir_nxt   = 1'b0;
`endif
                end
            end
            LOAD: begin
                tw_nxt    = start_q;
                vld_nxt   = 1'b1;
                cnt_nxt   = '0;
                state_nxt = DWELL;
            end
            DWELL: begin
                if (DDSEnable) begin
                    cnt_nxt = cnt_inc;
                    if (cnt_inc >= dwell_max) state_nxt = STEP;
                end
            end
            STEP: begin
                vld_nxt   = 1'b1;
                cnt_nxt   = '0;
                state_nxt = DWELL;
                if (no_sweep) begin
                    vld_nxt   = 1'b0;
                    state_nxt = FINISH;
`ifdef SWEEP_PINGPONG_EN
                end else if (dir && (TuningWord == start_q)) begin
                    vld_nxt   = 1'b0;
                    state_nxt = FINISH;
                end else if (!dir && (TuningWord != stop_q)) begin
                    tw_nxt    = up_tw;
                end else begin
                    // Reaching StopTW flips direction; the same step already heads down
                    dir_nxt   = 1'b1;
                    tw_nxt    = dn_tw;
                end
`else
                end else if (TuningWord == stop_q) begin
                    vld_nxt   = 1'b0;
                    state_nxt = FINISH;
                end else begin
                    tw_nxt    = up_tw;
                end
`endif
            end
            FINISH: begin
                done_nxt  = 1'b1;
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (Abort && (state != IDLE)) begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
            vld_nxt   = 1'b0;
            done_nxt  = 1'b0;
            tw_nxt    = TuningWord;
            cnt_nxt   = cnt;
        end
    end

    always_ff @(posedge Fg_CLK) begin
        if (!Fg_RESETn) begin
            start_q    <= '0;
            stop_q     <= '0;
            step_q     <= '0;
            dwell_q    <= '0;
            cnt        <= '0;
            TuningWord <= '0;
            TwValid    <= 1'b0;
            Busy       <= 1'b0;
            Done       <= 1'b0;
`ifdef SWEEP_PINGPONG_EN
            dir        <= 1'b0;
`endif
        end else begin
            start_q    <= start_nxt;
            stop_q     <= stop_nxt;
            step_q     <= step_nxt;
            dwell_q    <= dwell_nxt;
            cnt        <= cnt_nxt;
            TuningWord <= tw_nxt;
            TwValid    <= vld_nxt;
            Busy       <= busy_nxt;
            Done       <= done_nxt;
`ifdef SWEEP_PINGPONG_EN
            dir        <= dir_nxt;
`endif
        end
    end
endmodule

// File: tb/tb_dds_sweep_ctrl.sv
`timescale 1ns/1ps
// Bench for dds_sweep_ctrl: directed vector table, abort/reset sequences, randomized sweeps against a word-list model.
module tb_dds_sweep_ctrl;
    logic        clk, rst_n, DDSEnable, Start, Abort;
    logic [31:0] StartTW, StopTW, StepTW, TuningWord;
    logic [15:0] DwellCnt;
    logic        TwValid, Busy, Done;

    int total, bad;

    typedef struct {
        logic [31:0] s, e, st;
        logic [15:0] dw;
        int          period;
        int          n;
        logic [31:0] w[7];
    } vec_t;
    vec_t tbl[7];

    bit          tick_q[$], vld_q[$], done_q[$], busy_q[$];
    logic [31:0] tw_q[$];
    logic [31:0] exp_q[$];

    dds_sweep_ctrl #(.TW_W(32), .DWELL_W(16)) dut (
        .Fg_CLK(clk), .Fg_RESETn(rst_n), .DDSEnable(DDSEnable), .Start(Start), .Abort(Abort),
        .StartTW(StartTW), .StopTW(StopTW), .StepTW(StepTW), .DwellCnt(DwellCnt),
        .TuningWord(TuningWord), .TwValid(TwValid), .Busy(Busy), .Done(Done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic add_vec(input int i, input logic [31:0] s, e, st, input logic [15:0] dw, input int per,
                           input int n, input logic [31:0] w0, w1, w2, w3, w4, w5, w6);
        tbl[i].s = s; tbl[i].e = e; tbl[i].st = st; tbl[i].dw = dw; tbl[i].period = per; tbl[i].n = n;
        tbl[i].w[0] = w0; tbl[i].w[1] = w1; tbl[i].w[2] = w2; tbl[i].w[3] = w3;
        tbl[i].w[4] = w4; tbl[i].w[5] = w5; tbl[i].w[6] = w6;
    endtask

    // Expected word list straight from the sweep rules, in wide integer arithmetic
    task automatic build_model(input logic [31:0] s, e, st);
        longint w, t;
        exp_q.delete();
        w = s;
        exp_q.push_back(s);
        if (st != 0 && s < e) begin
            while (w != longint'(e)) begin
                t = w + longint'(st);
                w = (t >= longint'(e)) ? longint'(e) : t;
                exp_q.push_back(w[31:0]);
            end
`ifdef SWEEP_PINGPONG_EN
            while (w != longint'(s)) begin
                t = w - longint'(st);
                w = (t <= longint'(s)) ? longint'(s) : t;
                exp_q.push_back(w[31:0]);
            end
`endif
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after Done or budget expiry
    task automatic run_sweep(input logic [31:0] s, e, st, input logic [15:0] dw, input int period);
        int n;
        bit seen_done;
        tick_q.delete(); vld_q.delete(); done_q.delete(); busy_q.delete(); tw_q.delete();
        StartTW = s; StopTW = e; StepTW = st; DwellCnt = dw; Start = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0;
        StartTW = $urandom; StopTW = $urandom; StepTW = $urandom; DwellCnt = 16'($urandom);
        n = 0;
        seen_done = 1'b0;
        while (!seen_done && n < 3000) begin
            DDSEnable = (period == 0) ? ($urandom_range(0, 2) == 0) : ((n % period) == period - 1);
            @(negedge clk);
            tick_q.push_back(DDSEnable); vld_q.push_back(TwValid); done_q.push_back(Done);
            busy_q.push_back(Busy); tw_q.push_back(TuningWord);
            seen_done = Done;
            @(posedge clk); #1;
            n++;
        end
        DDSEnable = 1'b0;
        chk("sweep_reached_done", seen_done, 1);
    endtask

    task automatic check_sweep(input logic [15:0] dw);
        int vi[$];
        int di, ndone, errs, dmax, last, ticks;
        di = 0; ndone = 0; errs = 0;
        dmax = (dw == 0) ? 1 : int'(dw);
        for (int i = 0; i < vld_q.size(); i++) begin
            if (vld_q[i]) vi.push_back(i);
            if (done_q[i]) begin di = i; ndone++; end
            if (vld_q[i] && done_q[i]) errs++;
        end
        chk("n_words", vi.size(), exp_q.size());
        for (int i = 0; i < vi.size() && i < exp_q.size(); i++)
            chk("word", tw_q[vi[i]], exp_q[i]);
        chk("done_pulses", ndone, 1);
        if (vi.size() > 0) chk("load_latency", vi[0], 1);
        if (ndone == 1 && di >= 3) begin
            chk("busy_at_done", busy_q[di], 0);
            chk("done_word_held", tw_q[di], exp_q[exp_q.size()-1]);
            for (int i = 0; i < di; i++) if (!busy_q[i]) errs++;
            for (int i = 0; i < vi.size(); i++) begin
                last = (i + 1 < vi.size()) ? vi[i+1] - 2 : di - 3;
                ticks = 0;
                for (int j = vi[i]; j <= last; j++) ticks += int'(tick_q[j]);
                if (last < vi[i] || ticks != dmax || !tick_q[last]) errs++;
            end
        end
        chk("dwell_handshake_errs", errs, 0);
    endtask

    initial begin
        logic [31:0] rs, re, rst;
        logic [15:0] rdw;
        int span, cyc;
        bit found, seen_busy, seen_vld, seen_done;
        total = 0; bad = 0;
        rst_n = 1'b0; DDSEnable = 1'b0; Start = 1'b0; Abort = 1'b0;
        StartTW = '0; StopTW = '0; StepTW = '0; DwellCnt = '0;

`ifdef SWEEP_PINGPONG_EN
        add_vec(0, 100, 130, 10, 2, 1, 7, 100, 110, 120, 130, 120, 110, 100);
        add_vec(1, 100, 125, 10, 1, 1, 7, 100, 110, 120, 125, 115, 105, 100);
        add_vec(2, 32'hFFFFFFF0, 32'hFFFFFFFF, 32'h20, 2, 1, 3, 32'hFFFFFFF0, 32'hFFFFFFFF, 32'hFFFFFFF0, 0, 0, 0, 0);
        add_vec(3, 100, 130, 15, 0, 10, 5, 100, 115, 130, 115, 100, 0, 0);
        add_vec(6, 100, 120, 10, 1, 1, 5, 100, 110, 120, 110, 100, 0, 0);
`else
        add_vec(0, 100, 130, 10, 2, 1, 4, 100, 110, 120, 130, 0, 0, 0);
        add_vec(1, 100, 125, 10, 1, 1, 4, 100, 110, 120, 125, 0, 0, 0);
        add_vec(2, 32'hFFFFFFF0, 32'hFFFFFFFF, 32'h20, 2, 1, 2, 32'hFFFFFFF0, 32'hFFFFFFFF, 0, 0, 0, 0, 0);
        add_vec(3, 100, 130, 15, 0, 10, 3, 100, 115, 130, 0, 0, 0, 0);
        add_vec(6, 100, 120, 10, 1, 1, 3, 100, 110, 120, 0, 0, 0, 0);
`endif
        add_vec(4, 100, 130, 0, 0, 10, 1, 100, 0, 0, 0, 0, 0, 0);
        add_vec(5, 200, 100, 10, 1, 1, 1, 200, 0, 0, 0, 0, 0, 0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_tw", TuningWord, 0);
        chk("reset_vld", TwValid, 0);
        chk("reset_busy", Busy, 0);
        chk("reset_done", Done, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < 7; v++) begin
            exp_q.delete();
            for (int i = 0; i < tbl[v].n; i++) exp_q.push_back(tbl[v].w[i]);
            run_sweep(tbl[v].s, tbl[v].e, tbl[v].st, tbl[v].dw, tbl[v].period);
            check_sweep(tbl[v].dw);
            @(posedge clk); #1;
        end

        // Abort mid-dwell at 110, with an ignored Start while busy
        StartTW = 100; StopTW = 200; StepTW = 10; DwellCnt = 3; Start = 1'b1; DDSEnable = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (TwValid && TuningWord == 110) found = 1'b1;
            else begin @(posedge clk); #1; end
        end
        chk("abort_reached_110", found, 1);
        DDSEnable = 1'b0; Start = 1'b1; StartTW = 5000;
        @(posedge clk); #1;
        Start = 1'b0;
        @(negedge clk);
        chk("start_while_busy_busy", Busy, 1);
        chk("start_while_busy_tw", TuningWord, 110);
        chk("start_while_busy_vld", TwValid, 0);
        Abort = 1'b1;
        @(posedge clk); #1;
        Abort = 1'b0;
        @(negedge clk);
        chk("abort_busy", Busy, 0);
        chk("abort_done", Done, 0);
        chk("abort_vld", TwValid, 0);
        chk("abort_tw", TuningWord, 110);
        DDSEnable = 1'b1;
        seen_busy = 0; seen_vld = 0; seen_done = 0;
        repeat (10) begin
            @(negedge clk);
            seen_busy |= Busy; seen_vld |= TwValid; seen_done |= Done;
        end
        chk("post_abort_activity", {seen_busy, seen_vld, seen_done}, 0);
        chk("post_abort_tw", TuningWord, 110);

        // Abort and Start together in IDLE
        Start = 1'b1; Abort = 1'b1; StartTW = 7; StopTW = 70; StepTW = 7; DwellCnt = 1;
        @(posedge clk); #1;
        Start = 1'b0; Abort = 1'b0;
        seen_busy = 0; seen_vld = 0;
        repeat (6) begin
            @(negedge clk);
            seen_busy |= Busy; seen_vld |= TwValid;
        end
        chk("abort_start_idle", {seen_busy, seen_vld}, 0);

        // Reset mid-sweep
        @(posedge clk); #1;
        StartTW = 100; StopTW = 200; StepTW = 10; DwellCnt = 2; Start = 1'b1; DDSEnable = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("pre_reset_tw", TuningWord, 100);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midreset_tw", TuningWord, 0);
        chk("midreset_busy", Busy, 0);
        chk("midreset_vld_done", {TwValid, Done}, 0);
        seen_busy = 0; seen_done = 0;
        repeat (12) begin
            @(negedge clk);
            seen_busy |= Busy; seen_done |= Done;
        end
        chk("post_reset_idle", {seen_busy, seen_done}, 0);
        DDSEnable = 1'b0;
        @(posedge clk); #1;

        // Randomized sweeps against the model
        for (int r = 0; r < 25; r++) begin
            rs = (r % 5 == 0) ? 32'hFFFFFC00 + $urandom_range(0, 900) : $urandom_range(0, 1000);
            span = (r % 7 == 3) ? 0 : $urandom_range(1, 500);
            re = rs + span;
            rst = (r % 9 == 4) ? 0 : $urandom_range(span / 8 + 1, span + 20);
            rdw = 16'($urandom_range(0, 4));
            build_model(rs, re, rst);
            run_sweep(rs, re, rst, rdw, 0);
            check_sweep(rdw);
            cyc = $urandom_range(1, 3);
            repeat (cyc) @(posedge clk);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
